multi_axis_spinner: RTL and testbench

//  Digital-button to absolute-position emulator for spinner/trackball games; generalises
//  the single-axis spinner to AXES independent axes, any position width, and wrap or

---
 rtl/spinner_pkg.sv | 36 +++
 rtl/spinner_axis.sv | 89 ++++++++
 rtl/multi_axis_spinner.sv | 66 ++++++
 tb/tb_multi_axis_spinner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/spinner_pkg.sv
// Shared types and helpers for the multi-axis spinner.
//   dir_t     : direction requested by the buttons of one axis
//   spd_w     : width needed to hold a speed value in the range 1..ACC_MAX
//   next_pos  : applies a signed step to a position, then wraps or clamps it
package spinner_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_INC  = 2'd1,
    DIR_DEC  = 2'd2
  } dir_t;

  function automatic int spd_w(input int acc_max);
    return $clog2(acc_max + 1);
  endfunction

  // The arithmetic is done on a signed int, so it cannot overflow for
  // pos_w <= 30. In wrap mode a negative sum folds back through the two's
  // complement mask. In saturate mode the result is clamped to [0, 2^pos_w-1].
  function automatic int next_pos(input int old, input int step, input dir_t dir,
                                  input bit wrap, input int pos_w);
    int span;
    int sum;
    span = 1 << pos_w;
    case (dir)
      DIR_INC: sum = old + step;
      DIR_DEC: sum = old - step;
      default: sum = old;
    endcase
    if (wrap)          return sum & (span - 1);
    else if (sum < 0)  return 0;
    else if (sum >= span) return span - 1;
    else               return sum;
  endfunction

endpackage

// File: rtl/spinner_axis.sv
// One spinner axis. It holds the position, the acceleration speed, the last
// direction and the moved pulse for that axis.
// Ports:
//   clk_sys, reset     : clock and asynchronous active-high reset
//   upd                : one-cycle update strobe (from the frame tick edge)
//   clr                : synchronous clear; takes priority over upd
//   btn_inc/dec/acc    : the button inputs for this axis
//   pos                : absolute position
//   moved              : one-cycle pulse that follows an update which changed pos
module spinner_axis
  import spinner_pkg::*;
#(
  parameter int              POS_W   = 8,
  parameter int              ACC_MAX = 4,
  parameter logic [POS_W-1:0] CENTER = {1'b1, {(POS_W-1){1'b0}}},
  parameter bit              WRAP    = 1'b1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             upd,
  input  logic             clr,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             btn_acc,
  output logic [POS_W-1:0] pos,
  output logic             moved
);

  localparam int SW = spd_w(ACC_MAX);

  logic [POS_W-1:0] pos_q, pos_d;
  logic [SW-1:0]    spd_q, spd_d;
  dir_t             dir_q, dir_d;
  dir_t             dir_now;
  logic             moved_q, moved_d;
  int               step;
  int               spd_nxt;

  always_comb begin
    dir_now = DIR_NONE;
    if (btn_inc & ~btn_dec)      dir_now = DIR_INC;
    else if (btn_dec & ~btn_inc) dir_now = DIR_DEC;

    pos_d   = pos_q;
    spd_d   = spd_q;
    dir_d   = dir_q;
    moved_d = 1'b0;
    step    = 0;
    spd_nxt = 1;

    if (clr) begin
      pos_d = CENTER;
      spd_d = SW'(1);
      dir_d = DIR_NONE;
    end else if (upd) begin
      if (dir_now == DIR_NONE) begin
        spd_d = SW'(1);
        dir_d = DIR_NONE;
      end else begin
        // A reversal, or a start from rest, always begins with a single step.
        // The ramp then continues from the step that was just taken.
        step = (dir_now != dir_q) ? 1 : int'(spd_q);
        if (btn_acc) spd_nxt = (step + 1 > ACC_MAX) ? ACC_MAX : step + 1;
        spd_d   = SW'(spd_nxt);
        dir_d   = dir_now;
        pos_d   = POS_W'(next_pos(int'(pos_q), step, dir_now, WRAP, POS_W));
        moved_d = (pos_d != pos_q);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pos_q   <= CENTER;
      spd_q   <= SW'(1);
      dir_q   <= DIR_NONE;
      moved_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      spd_q   <= spd_d;
      dir_q   <= dir_d;
      moved_q <= moved_d;
    end
  end

  assign pos   = pos_q;
  assign moved = moved_q;

endmodule

// File: rtl/multi_axis_spinner.sv
// Converts digital buttons into absolute spinner/trackball positions for AXES
// independent axes. The positions update once on each rising edge of the frame
// tick.
// Ports:
//   clk_sys   : system clock
//   reset     : asynchronous active-high reset
//   tick      : frame tick level; each rising edge is one update
//   pos_clear : synchronous clear of all axes to CENTER
//   btn_inc   : per-axis increment buttons [AXES]
//   btn_dec   : per-axis decrement buttons [AXES]
//   btn_acc   : per-axis acceleration enables [AXES]
//   pos       : positions; axis i is at [i*POS_W +: POS_W]
//   moved     : per-axis one-cycle pulse that follows a position change
module multi_axis_spinner
  import spinner_pkg::*;
#(
  parameter int              AXES    = 2,
  parameter int              POS_W   = 8,
  parameter int              ACC_MAX = 4,
  parameter logic [POS_W-1:0] CENTER = {1'b1, {(POS_W-1){1'b0}}},
  parameter bit              WRAP    = 1'b1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  pos_clear,
  input  logic [AXES-1:0]       btn_inc,
  input  logic [AXES-1:0]       btn_dec,
  input  logic [AXES-1:0]       btn_acc,
  output logic [AXES*POS_W-1:0] pos,
  output logic [AXES-1:0]       moved
);

  logic tick_q, tick_d;
  logic upd;

  always_comb begin
    tick_d = tick;
    upd    = tick & ~tick_q;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) tick_q <= 1'b0;
    else       tick_q <= tick_d;
  end

  for (genvar i = 0; i < AXES; i++) begin : g_axis
    spinner_axis #(
      .POS_W  (POS_W),
      .ACC_MAX(ACC_MAX),
      .CENTER (CENTER),
      .WRAP   (WRAP)
    ) u_axis (
      .clk_sys(clk_sys),
      .reset  (reset),
      .upd    (upd),
      .clr    (pos_clear),
      .btn_inc(btn_inc[i]),
      .btn_dec(btn_dec[i]),
      .btn_acc(btn_acc[i]),
      .pos    (pos[i*POS_W +: POS_W]),
      .moved  (moved[i])
    );
  end

endmodule

// File: tb/tb_multi_axis_spinner.sv
// Testbench for multi_axis_spinner. It drives a wrapping instance and a
// saturating instance from the same inputs and checks both against an
// arithmetic reference model.
module tb_multi_axis_spinner;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        pos_clear;
  logic [1:0]  btn_inc, btn_dec, btn_acc;
  logic [15:0] pos_w, pos_s;
  logic [1:0]  moved_w, moved_s;

  int checks   = 0;
  int failures = 0;

  // Reference model state, indexed [instance][axis]. Instance 0 wraps and
  // instance 1 saturates.
  int mpos [2][2];
  int mspd [2][2];
  int mdir [2][2];
  int mmov [2][2];
  int mtick;
  logic [1:0] last_mov_w, last_mov_s;

  always #5 clk = ~clk;

  multi_axis_spinner #(.AXES(2), .POS_W(8), .ACC_MAX(4), .CENTER(8'h80), .WRAP(1'b1)) u_wrap (
    .clk_sys(clk), .reset(reset), .tick(tick), .pos_clear(pos_clear),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_acc(btn_acc),
    .pos(pos_w), .moved(moved_w)
  );

  multi_axis_spinner #(.AXES(2), .POS_W(8), .ACC_MAX(4), .CENTER(8'h80), .WRAP(1'b0)) u_sat (
    .clk_sys(clk), .reset(reset), .tick(tick), .pos_clear(pos_clear),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_acc(btn_acc),
    .pos(pos_s), .moved(moved_s)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int a = 0; a < 2; a++) begin
        mpos[w][a] = 128; mspd[w][a] = 1; mdir[w][a] = 0; mmov[w][a] = 0;
      end
    mtick = 0;
  endtask

  // The model advances by one clock, using the inputs present at that edge.
  task automatic model_clk(input logic t, input logic [1:0] inc, input logic [1:0] dec,
                           input logic [1:0] acc, input logic c);
    bit upd;
    int d, step, np;
    upd   = t && (mtick == 0);
    mtick = t ? 1 : 0;
    for (int w = 0; w < 2; w++)
      for (int a = 0; a < 2; a++) begin
        mmov[w][a] = 0;
        if (c) begin
          mpos[w][a] = 128; mspd[w][a] = 1; mdir[w][a] = 0;
        end else if (upd) begin
          d = (inc[a] && !dec[a]) ? 1 : ((dec[a] && !inc[a]) ? -1 : 0);
          if (d == 0) begin
            mspd[w][a] = 1; mdir[w][a] = 0;
          end else begin
            step = (d != mdir[w][a]) ? 1 : mspd[w][a];
            mspd[w][a] = acc[a] ? ((step + 1 > 4) ? 4 : step + 1) : 1;
            mdir[w][a] = d;
            np = mpos[w][a] + d * step;
            if (w == 0) np = (np + 256) % 256;
            else if (np < 0) np = 0;
            else if (np > 255) np = 255;
            mmov[w][a] = (np != mpos[w][a]) ? 1 : 0;
            mpos[w][a] = np;
          end
        end
      end
  endtask

  task automatic compare_all();
    for (int a = 0; a < 2; a++) begin
      check($sformatf("wrap_pos%0d", a),   int'(pos_w[a*8 +: 8]), mpos[0][a]);
      check($sformatf("sat_pos%0d", a),    int'(pos_s[a*8 +: 8]), mpos[1][a]);
      check($sformatf("wrap_moved%0d", a), int'(moved_w[a]),      mmov[0][a]);
      check($sformatf("sat_moved%0d", a),  int'(moved_s[a]),      mmov[1][a]);
    end
  endtask

  task automatic cyc(input logic t, input logic [1:0] inc, input logic [1:0] dec,
                     input logic [1:0] acc, input logic c);
    tick = t; btn_inc = inc; btn_dec = dec; btn_acc = acc; pos_clear = c;
    @(posedge clk);
    model_clk(t, inc, dec, acc, c);
    #1;
    compare_all();
  endtask

  task automatic tick_edge(input logic [1:0] inc, input logic [1:0] dec, input logic [1:0] acc);
    cyc(1'b1, inc, dec, acc, 1'b0);
    last_mov_w = moved_w;
    last_mov_s = moved_s;
    cyc(1'b0, inc, dec, acc, 1'b0);
  endtask

  initial begin
    logic [1:0] r_inc, r_dec, r_acc;
    logic       r_tick;

    reset = 1'b1; tick = 1'b0; pos_clear = 1'b0;
    btn_inc = '0; btn_dec = '0; btn_acc = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pos_wrap", int'(pos_w), 16'h8080);
    check("reset_moved", int'(moved_w | moved_s), 0);
    reset = 1'b0;

    // Idle ticks produce no movement.
    repeat (3) tick_edge(2'b00, 2'b00, 2'b00);
    check("idle_pos", int'(pos_w), 16'h8080);

    // Axis 0 is incremented without acceleration.
    repeat (3) tick_edge(2'b01, 2'b00, 2'b00);
    check("inc_noacc_pos0", int'(pos_w[7:0]), 8'h83);
    check("inc_noacc_pos1", int'(pos_w[15:8]), 8'h80);
    check("inc_noacc_moved", int'(last_mov_w), 2'b01);

    // Acceleration ramp, then a reversal.
    cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    repeat (6) tick_edge(2'b01, 2'b00, 2'b01);
    check("ramp_pos0", int'(pos_w[7:0]), 8'h92);
    tick_edge(2'b00, 2'b01, 2'b01);
    check("reverse_pos0", int'(pos_w[7:0]), 8'h91);

    // Walk axis 0 down to 1 so that the next step (size 3) crosses zero.
    cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    repeat (32) tick_edge(2'b00, 2'b01, 2'b01);
    check("descent_pos0", int'(pos_w[7:0]), 6);
    tick_edge(2'b00, 2'b00, 2'b00);
    repeat (2) tick_edge(2'b00, 2'b01, 2'b00);
    tick_edge(2'b00, 2'b00, 2'b00);
    repeat (2) tick_edge(2'b00, 2'b01, 2'b01);
    check("pre_wrap_pos0", int'(pos_w[7:0]), 8'h01);
    tick_edge(2'b00, 2'b01, 2'b01);
    check("wrap_pos0", int'(pos_w[7:0]), 8'hFE);
    check("wrap_moved0", int'(last_mov_w[0]), 1);
    check("sat_pos0", int'(pos_s[7:0]), 8'h00);
    check("sat_moved0", int'(last_mov_s[0]), 1);
    tick_edge(2'b00, 2'b01, 2'b01);
    check("sat_hold_pos0", int'(pos_s[7:0]), 8'h00);
    check("sat_hold_moved0", int'(last_mov_s[0]), 0);

    // A clear that coincides with an update wins, and the update is lost.
    cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc(1'b1, 2'b01, 2'b00, 2'b00, 1'b1);
    check("clear_upd_pos0", int'(pos_w[7:0]), 8'h80);
    check("clear_upd_moved", int'(moved_w), 0);
    cyc(1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
    tick_edge(2'b01, 2'b00, 2'b00);
    check("after_clear_pos0", int'(pos_w[7:0]), 8'h81);

    // Both buttons held gives no movement. Then an asynchronous reset arrives mid-ramp.
    tick_edge(2'b01, 2'b01, 2'b00);
    check("both_btn_pos0", int'(pos_w[7:0]), 8'h81);
    repeat (2) tick_edge(2'b01, 2'b00, 2'b01);
    check("ramp2_pos0", int'(pos_w[7:0]), 8'h84);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_wrap", int'(pos_w), 16'h8080);
    check("async_reset_sat", int'(pos_s), 16'h8080);
    #2 reset = 1'b0;
    tick_edge(2'b01, 2'b00, 2'b01);
    check("post_reset_pos0", int'(pos_w[7:0]), 8'h81);

    // Random stimulus. The buttons are held for stretches so that ramps build up.
    r_inc = '0; r_dec = '0; r_acc = '0; r_tick = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) r_inc = 2'($urandom);
      if ($urandom_range(0, 7) == 0) r_dec = 2'($urandom);
      if ($urandom_range(0, 15) == 0) r_acc = 2'($urandom);
      if ($urandom_range(0, 2) == 0) r_tick = ~r_tick;
      cyc(r_tick, r_inc, r_dec, r_acc, ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
